uart_tx_fifo: RTL and testbench

- 8N1 serial transmitter with a small write FIFO. It is the transmit-side counterpart to the team's serial receive path.
- The CPU or I/O bus pushes bytes. The block serialises each byte onto txd, LSB first, with one start bit and one stop bit.
- Bit timing comes from a fixed clock divider, so no baud-rate clock input is needed.
- Sits on the I/O side of the single-clock system, next to the receiver and the keyboard/VGA blocks.

---
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 serial transmitter fed by a small write FIFO; bit timing from a fixed clock divider.
// txd is registered from the FSM state, so the line lags the state by one cycle.
module uart_tx_fifo #(
    parameter int DIV   = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    din,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic          busy,
    output logic          txd
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;
    logic          last_tick;
    logic          tx_bit;

    assign last_tick = (div_cnt == DW'(DIV - 1));
    // full/empty are the registered pre-edge flags, so a push into a full FIFO
    // is rejected even when the same edge pops.
    assign push = wr_en && !full;
    assign pop  = !empty && ((state == IDLE) || (state == STOP && last_tick));

    always_comb begin
        count_next = level;
        if (push && !pop) begin
            count_next = level + (AW+1)'(1);
        end else if (!push && pop) begin
            count_next = level - (AW+1)'(1);
        end
    end

    always_comb begin
        tx_bit = 1'b1;
        case (state)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shift[0];
            default: tx_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && full) begin
                ovf <= 1'b1;
            end
            level <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
            busy    <= 1'b0;
        end else begin
            txd <= tx_bit;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (!empty) begin
                        state <= START;
                        shift <= mem[rd_ptr];
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (last_tick) begin
                        state   <= DATA;
                        div_cnt <= '0;
                        bit_idx <= '0;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        div_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                STOP: begin
                    if (last_tick) begin
                        div_cnt <= '0;
                        if (!empty) begin
                            state <= START;
                            shift <= mem[rd_ptr];
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DIV=4, DEPTH=4: per-cycle vector table for reset and a single
// frame, hand-written sequences for back-to-back, overflow, full-with-pop and mid-frame reset.
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FRAME = 10 * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;
    logic          busy;
    logic          txd;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];

    typedef struct {
        logic        rst;
        logic        wr_en;
        logic [7:0]  din;
        logic        txd;
        logic        busy;
        logic        empty;
        logic        full;
        logic        ovf;
        logic [AW:0] level;
    } vec_t;

    vec_t vecs[$];

    uart_tx_fifo #(.DIV(DIV), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (din),
        .full  (full),
        .empty (empty),
        .level (level),
        .ovf   (ovf),
        .busy  (busy),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic r, input logic w, input logic [7:0] d, input logic t,
                           input logic b, input logic e, input logic f, input logic o,
                           input logic [AW:0] l);
        vec_t v;
        v.rst = r; v.wr_en = w; v.din = d; v.txd = t; v.busy = b;
        v.empty = e; v.full = f; v.ovf = o; v.level = l;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        exp_q.delete();
        rx_q.delete();
        start_q.delete();
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        din = b;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy && empty) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        check({name, "_idle_timeout"}, {31'd0, done}, 32'd1);
        repeat (4) cycle();
    endtask

    task automatic compare_rx(input string name);
        check({name, "_frame_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            check({name, "_byte"}, {24'd0, rx_q.pop_front()}, {24'd0, exp_q.pop_front()});
        end
    endtask

    // Independent 8N1 receiver: samples each bit in the middle of its DIV-cycle slot.
    initial begin
        bit         in_frame = 1'b0;
        bit         prev = 1'b1;
        int         pos = 0;
        logic [7:0] sh = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_frame = 1'b0;
                prev = 1'b1;
            end else begin
                if (!in_frame) begin
                    if (prev && !txd) begin
                        in_frame = 1'b1;
                        pos = 0;
                        sh = 8'h00;
                        start_q.push_back(cyc);
                    end
                end else begin
                    pos++;
                    if (pos == DIV / 2) begin
                        check("rx_start_bit", {31'd0, txd}, 32'd0);
                    end else if (pos > DIV && pos < 9 * DIV && (pos % DIV) == DIV / 2) begin
                        sh = {txd, sh[7:1]};
                    end else if (pos == 9 * DIV + DIV / 2) begin
                        check("rx_stop_bit", {31'd0, txd}, 32'd1);
                        rx_q.push_back(sh);
                        in_frame = 1'b0;
                    end
                end
                prev = txd;
            end
        end
    end

    initial begin
        logic [9:0] fr;
        bit         stayed_high;
        fr = {1'b1, 8'hA5, 1'b0};

        // Vector table: 3 reset cycles, 50 idle, push 0xA5, then the full frame.
        for (int i = 0; i < 3; i++)  add_vec(1, 0, 8'h00, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 50; i++) add_vec(0, 0, 8'h00, 1, 0, 1, 0, 0, 0);
        add_vec(0, 1, 8'hA5, 1, 0, 0, 0, 0, 1);
        add_vec(0, 0, 8'h00, 1, 1, 1, 0, 0, 0);
        for (int k = 0; k < FRAME; k++) begin
            add_vec(0, 0, 8'h00, fr[k / DIV], (k < FRAME - 1) ? 1'b1 : 1'b0, 1, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++)  add_vec(0, 0, 8'h00, 1, 0, 1, 0, 0, 0);

        exp_q.push_back(8'hA5);
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            wr_en = vecs[i].wr_en;
            din = vecs[i].din;
            cycle();
            check($sformatf("vec%0d_txd", i),   {31'd0, txd},   {31'd0, vecs[i].txd});
            check($sformatf("vec%0d_busy", i),  {31'd0, busy},  {31'd0, vecs[i].busy});
            check($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].empty});
            check($sformatf("vec%0d_full", i),  {31'd0, full},  {31'd0, vecs[i].full});
            check($sformatf("vec%0d_ovf", i),   {31'd0, ovf},   {31'd0, vecs[i].ovf});
            check($sformatf("vec%0d_level", i), {29'd0, level}, {29'd0, vecs[i].level});
        end
        wr_en = 1'b0;
        compare_rx("single");

        // Back-to-back: three frames with no idle gap between them.
        do_reset();
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        check("b2b_level", {29'd0, level}, 32'd2);
        wait_idle("b2b", 400);
        check("b2b_starts", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_gap01", start_q[1] - start_q[0], FRAME);
            check("b2b_gap12", start_q[2] - start_q[1], FRAME);
        end
        compare_rx("b2b");

        // Full FIFO on the STOP->START pop edge: push rejected, level 4 -> 3.
        do_reset();
        push(8'hA1);
        wr_en = 1'b1;
        din = 8'hB2; cycle();
        din = 8'hC3; cycle();
        din = 8'hD4; cycle();
        din = 8'hE5; cycle();
        wr_en = 1'b0;
        check("fpop_full_before", {31'd0, full}, 32'd1);
        check("fpop_level_before", {29'd0, level}, 32'd4);
        repeat (36) cycle();
        check("fpop_ovf_before", {31'd0, ovf}, 32'd0);
        check("fpop_busy_before", {31'd0, busy}, 32'd1);
        wr_en = 1'b1;
        din = 8'hF6;
        cycle();
        check("fpop_level_popedge", {29'd0, level}, 32'd3);
        check("fpop_full_popedge", {31'd0, full}, 32'd0);
        check("fpop_ovf_popedge", {31'd0, ovf}, 32'd1);
        din = 8'h17;
        cycle();
        wr_en = 1'b0;
        check("fpop_level_after", {29'd0, level}, 32'd4);
        check("fpop_full_after", {31'd0, full}, 32'd1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
        exp_q.push_back(8'hD4); exp_q.push_back(8'hE5); exp_q.push_back(8'h17);
        wait_idle("fpop", 600);
        compare_rx("fpop");

        // Overflow: six consecutive pushes from idle, byte 1 popped during byte 2.
        do_reset();
        wr_en = 1'b1;
        din = 8'h11; cycle();
        din = 8'h22; cycle();
        din = 8'h33; cycle();
        din = 8'h44; cycle();
        din = 8'h55; cycle();
        check("ovf_full_5th", {31'd0, full}, 32'd1);
        check("ovf_level_5th", {29'd0, level}, 32'd4);
        check("ovf_flag_5th", {31'd0, ovf}, 32'd0);
        din = 8'h66; cycle();
        wr_en = 1'b0;
        check("ovf_flag_6th", {31'd0, ovf}, 32'd1);
        check("ovf_level_6th", {29'd0, level}, 32'd4);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        exp_q.push_back(8'h44); exp_q.push_back(8'h55);
        wait_idle("ovf", 500);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        compare_rx("ovf");

        // Reset during data bit 3 of 0x81 with two bytes queued.
        do_reset();
        push(8'h81);
        push(8'h5A);
        push(8'h3C);
        repeat (16) cycle();
        check("rst_mid_txd_before", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_mid_txd", {31'd0, txd}, 32'd1);
        check("rst_mid_level", {29'd0, level}, 32'd0);
        check("rst_mid_empty", {31'd0, empty}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        stayed_high = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (txd !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
        end
        check("rst_mid_quiet", {31'd0, stayed_high}, 32'd1);
        compare_rx("rst_mid");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
